mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8, 32 or 64.
REQ-002 Parameter ADDR_W, default 32: request byte-address width.
REQ-003 Parameter DEPTH_LOG2, default 10: log2 of the word count of the internal array.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when high with req_valid.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  access is 2^req_size bytes.
REQ-010 req_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  DATA_W  store data, right-justified.
REQ-013 rsp_valid  out  1  response present; held until rsp_ready.
REQ-014 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-015 rsp_rdata  out  DATA_W  load data, right-justified and extended; 0 for stores and errors.
REQ-016 rsp_err  out  1  misaligned, oversize or out-of-range access.
REQ-017 dbg_mode  in  1  debug inspection request.
REQ-018 dbg_addr  in  DEPTH_LOG2  debug word index.
REQ-019 dbg_rdata  out  DATA_W  debug read data, one cycle behind dbg_addr.

Function
REQ-020 The block SHALL decode word index as req_addr[DEPTH_LOG2+LB-1:LB] and lane offset as req_addr[LB-1:0], with LB = log2(DATA_W/8).
REQ-021 The block SHALL flag an error when req_addr mod 2^req_size != 0, when 2^req_size > DATA_W/8, or when any req_addr bit at or above DEPTH_LOG2+LB is set.
REQ-022 An erroring request SHALL neither write nor read the array.
REQ-023 The FSM SHALL have states IDLE, RD, RSP and DBG, with req_ready = 1 only in IDLE and dbg_mode = 0.
REQ-024 IDLE, accepted load with no error -> RD; array read issued at the accept edge.
REQ-025 IDLE, accepted store or error -> RSP; store bytes commit at the accept edge via per-byte enables, other lanes unchanged.
REQ-026 RD -> RSP after one cycle; the aligned, extended load data SHALL be registered into rsp_rdata.
REQ-027 rsp_valid SHALL be 1 exactly in RSP. rsp_rdata and rsp_err SHALL stay stable until RSP exits on rsp_valid & rsp_ready, returning to IDLE.
REQ-028 Latency from the accept edge to rsp_valid high: load 2 cycles; store or error 1 cycle.
REQ-029 Load extension SHALL fill bits [DATA_W-1 : 8*2^req_size] with the access MSB if req_signed, else zeros; req_signed is ignored for full-width loads.
REQ-030 In IDLE with dbg_mode = 1 the FSM SHALL move to DBG. Requests in RD or RSP SHALL complete first.
REQ-031 DBG: no array writes; dbg_rdata is updated every cycle from dbg_addr. Exit to IDLE when dbg_mode = 0.
REQ-032 Outside DBG, dbg_rdata SHALL hold its last value.
REQ-033 When req_valid and dbg_mode rise together in IDLE, debug SHALL win and the request SHALL not be accepted.

Reset
REQ-034 While rst_n = 0: state IDLE, req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, dbg_rdata = 0.
REQ-035 Array contents SHALL not be reset.
REQ-036 Reset asserted mid-operation SHALL drop any pending response.
REQ-037 A store whose accept edge coincides with reset assertion SHALL not commit.
REQ-038 req_ready SHALL rise one cycle after rst_n deasserts.

Structure
REQ-039 Package mem_access_pkg SHALL hold the size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3), the FSM state type, and a function giving the byte-enable mask from size and offset.
REQ-040 Sub-module mem_lane_align (combinational) SHALL perform store lane replication / byte-enable generation and load lane extraction / extension.
REQ-041 The array SHALL be inferred in mem_access_ctrl as byte-writable synchronous-read RAM.

Verification
REQ-042 Store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after load accept.
REQ-043 After REQ-042: store byte 0x80 @0x11; signed byte load @0x11 -> 0xFFFFFF80; unsigned -> 0x00000080; word load @0x10 -> 0xDEAD80EF.
REQ-044 Half load @0x13 -> rsp_err=1, rsp_rdata=0, memory unchanged; address 0x1000 with DEPTH_LOG2=10 -> rsp_err=1.
REQ-045 Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
REQ-046 Raise dbg_mode during RD -> load response delivered first, then DBG. A store attempted in DBG is not accepted. dbg_addr=4 -> dbg_rdata=0xDEAD80EF next cycle.
REQ-047 Assert rst_n=0 while in RSP -> rsp_valid=0 immediately; after release, word @0x10 still reads 0xDEAD80EF.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access controller.
// Size codes, FSM state type and the byte-enable mask function.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StRsp,
    StDbg
  } state_e;

  localparam int unsigned MaxLanes = 8;

  // Lane mask for an aligned access of 2^size bytes starting at byte lane `offset`.
  function automatic logic [MaxLanes-1:0] byte_mask(size_e size, logic [2:0] offset);
    logic [MaxLanes-1:0] ones;
    case (size)
      SZ_BYTE: ones = 8'h01;
      SZ_HALF: ones = 8'h03;
      SZ_WORD: ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    return ones << offset;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response bus between a requester (master) and mem_access_ctrl (slave).
interface mem_access_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store data replication and byte enables on the way in,
// load lane extraction with sign/zero extension on the way out.
module mem_lane_align import mem_access_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned NumLanes = DATA_W / 8,
  localparam int unsigned LaneBits = $clog2(NumLanes)
) (
  input  size_e                st_size_i,
  input  logic [LaneBits-1:0]  st_offset_i,
  input  logic [DATA_W-1:0]    st_wdata_i,
  output logic [DATA_W-1:0]    st_wdata_o,
  output logic [NumLanes-1:0]  st_byte_en_o,

  input  size_e                ld_size_i,
  input  logic [LaneBits-1:0]  ld_offset_i,
  input  logic                 ld_signed_i,
  input  logic [DATA_W-1:0]    ld_word_i,
  output logic [DATA_W-1:0]    ld_data_o
);

  localparam int unsigned IdxBits = $clog2(DATA_W);

  // Replicating the access across all lanes lets the byte enables alone pick the target.
  always_comb begin
    st_wdata_o = st_wdata_i;
    case (st_size_i)
      SZ_BYTE: st_wdata_o = {NumLanes{st_wdata_i[7:0]}};
      SZ_HALF: st_wdata_o = {(NumLanes / 2){st_wdata_i[15:0]}};
      SZ_WORD: st_wdata_o = {(NumLanes / 4){st_wdata_i[31:0]}};
      default: st_wdata_o = st_wdata_i;
    endcase
    st_byte_en_o = NumLanes'(byte_mask(st_size_i, 3'(ld_offset_zero_ext(st_offset_i))));
  end

  function automatic logic [LaneBits-1:0] ld_offset_zero_ext(logic [LaneBits-1:0] off);
    return off;
  endfunction

  always_comb begin
    int unsigned        bits;
    int unsigned        msb_idx;
    logic [DATA_W-1:0]  shifted;
    logic [DATA_W-1:0]  keep;
    logic               fill;
    bits    = 32'd8 << ld_size_i;
    msb_idx = (bits < DATA_W) ? bits - 1 : DATA_W - 1;
    shifted = ld_word_i >> {ld_offset_i, 3'b000};
    keep    = (bits >= DATA_W) ? '1 : ((DATA_W'(1) << bits) - DATA_W'(1));
    fill    = ld_signed_i & shifted[msb_idx[IdxBits-1:0]];
    ld_data_o = (shifted & keep) | ({DATA_W{fill}} & ~keep);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-port byte-writable memory behind a valid/ready request/response bus,
// with a debug inspection mode that reads words while requests are blocked.
module mem_access_ctrl import mem_access_pkg::*; #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_if.slave           bus,
  input  logic                  dbg_mode,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_rdata
);

  localparam int unsigned NumLanes = DATA_W / 8;
  localparam int unsigned LaneBits = $clog2(NumLanes);
  localparam int unsigned Words    = 1 << DEPTH_LOG2;
  localparam int unsigned TopBit   = DEPTH_LOG2 + LaneBits;

  state_e state_q, state_d;
  logic   ready_en_q;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [LaneBits-1:0]   lane_off;
  size_e                 req_sz;
  logic                  req_err;
  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;

  logic [DATA_W-1:0]   mem_q [Words];
  logic [DATA_W-1:0]   rd_word_q;
  logic [DATA_W-1:0]   st_wdata;
  logic [NumLanes-1:0] st_byte_en;
  logic [DATA_W-1:0]   ld_data;

  size_e               ld_size_q;
  logic [LaneBits-1:0] ld_off_q;
  logic                ld_signed_q;

  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  assign word_idx = bus.req_addr[TopBit-1:LaneBits];
  assign lane_off = bus.req_addr[LaneBits-1:0];
  assign req_sz   = size_e'(bus.req_size);

  always_comb begin
    int unsigned span;
    logic        misalign;
    logic        oversize;
    logic        out_of_range;
    span         = 32'd1 << bus.req_size;
    misalign     = (32'(lane_off) & (span - 32'd1)) != 32'd0;
    oversize     = span > NumLanes;
    out_of_range = (bus.req_addr >> TopBit) != '0;
    req_err      = misalign | oversize | out_of_range;
  end

  assign bus.req_ready = ready_en_q && (state_q == StIdle) && !dbg_mode;
  assign accept        = bus.req_valid && bus.req_ready;
  // rst_n in the enable keeps a store from landing on the edge reset is asserted.
  assign wr_en         = accept && bus.req_write && !req_err && rst_n;
  assign rd_en         = accept && !bus.req_write && !req_err;

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .st_size_i    (req_sz),
    .st_offset_i  (lane_off),
    .st_wdata_i   (bus.req_wdata),
    .st_wdata_o   (st_wdata),
    .st_byte_en_o (st_byte_en),
    .ld_size_i    (ld_size_q),
    .ld_offset_i  (ld_off_q),
    .ld_signed_i  (ld_signed_q),
    .ld_word_i    (rd_word_q),
    .ld_data_o    (ld_data)
  );

  // Array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NumLanes; b++) begin
        if (st_byte_en[b]) mem_q[word_idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
    if (rd_en) rd_word_q <= mem_q[word_idx];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (dbg_mode) begin
          state_d = StDbg;
        end else if (accept) begin
          state_d = (bus.req_write || req_err) ? StRsp : StRd;
        end
      end
      StRd:  state_d = StRsp;
      StRsp: if (bus.rsp_ready) state_d = StIdle;
      StDbg: if (!dbg_mode) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_en_q  <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      dbg_rdata_q <= '0;
      ld_size_q   <= SZ_BYTE;
      ld_off_q    <= '0;
      ld_signed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (accept) begin
        rsp_err_q   <= req_err;
        rsp_rdata_q <= '0;
        ld_size_q   <= req_sz;
        ld_off_q    <= lane_off;
        ld_signed_q <= bus.req_signed;
      end else if (state_q == StRd) begin
        rsp_rdata_q <= ld_data;
      end
      if (state_q == StDbg) dbg_rdata_q <= mem_q[dbg_addr];
    end
  end

  assign bus.rsp_valid = (state_q == StRsp);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_rdata     = dbg_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand-written corner
// sequences, then random traffic against a byte-array reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbg_mode;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  always #5 clk = ~clk;

  mem_access_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_access_ctrl #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .DEPTH_LOG2 (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_mode  (dbg_mode),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Reference model: plain byte-addressed little-endian memory of 4 KiB.
  logic [7:0] model_mem [4096];

  function automatic void model_op(input logic wr, input int sz, input logic sg,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   output logic [31:0] rd, output logic err, output int lat);
    int n;
    logic [31:0] v;
    n   = 1 << sz;
    err = ((addr % n) != 0) || (n > 4) || (addr >= 32'd4096);
    rd  = 32'h0;
    lat = 1;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) model_mem[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(model_mem[int'(addr) + i]) << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd  = v;
        lat = 2;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    n = 0;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    issue(wr, sz, sg, addr, wd);
    wait_rsp(lat);
    check({name, ".lat"}, 32'(lat), 32'(exp_lat));
    check({name, ".rdata"}, bus.rsp_rdata, exp_rd);
    check({name, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
    consume();
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          lat;
    logic [31:0] m_rd;
    logic        m_err;
    int          m_lat;

    rst_n          = 1'b0;
    dbg_mode       = 1'b0;
    dbg_addr       = '0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.req_ready", 32'(bus.req_ready), 32'd0);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst.dbg_rdata", dbg_rdata, 32'd0);
    rst_n = 1'b1;
    #1 check("rel.req_ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("rel.req_ready_high", 32'(bus.req_ready), 32'd1);

    // Directed vectors
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h00, 32'h0BADF00D, 32'h0, 1'b0, 1});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h11, 32'h00000080, 32'h0, 1'b0, 1});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h00000080, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h13, 32'h1234, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1000, 32'h55555555, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0, 2});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'h0BADF00D, 1'b0, 2});
    foreach (vecs[i]) begin
      do_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Response backpressure
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_rsp(lat);
    check("bp.lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d.rdata", i), bus.rsp_rdata, 32'hDEAD80EF);
      check($sformatf("bp%0d.req_ready", i), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    consume();
    check("bp.done", 32'(bus.rsp_valid), 32'd0);

    // Debug raised during a load: load completes, then DBG blocks a store
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    dbg_mode = 1'b1;
    wait_rsp(lat);
    check("dbg.load_lat", 32'(lat), 32'd2);
    check("dbg.load_rdata", bus.rsp_rdata, 32'hDEAD80EF);
    consume();
    bus.req_write = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h11111111;
    bus.req_valid = 1'b1;
    dbg_addr      = 10'd4;
    @(negedge clk);
    @(negedge clk);
    check("dbg.rdata", dbg_rdata, 32'hDEAD80EF);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dbg%0d.req_ready", i), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    dbg_mode = 1'b0;
    @(negedge clk);
    dbg_addr = 10'd0;
    repeat (3) @(negedge clk);
    check("dbg.hold", dbg_rdata, 32'hDEAD80EF);

    // Request and debug rising together: debug wins
    bus.req_wdata = 32'h22222222;
    bus.req_valid = 1'b1;
    dbg_mode      = 1'b1;
    #1 check("race.req_ready", 32'(bus.req_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("race.no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("race.dbg_word0", dbg_rdata, 32'h0BADF00D);
    bus.req_valid = 1'b0;
    @(negedge clk);
    dbg_mode = 1'b0;
    @(negedge clk);

    // Reset while a response is pending
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_rsp(lat);
    check("rsp_rst.valid_before", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rsp_rst.valid", 32'(bus.rsp_valid), 32'd0);
    check("rsp_rst.rdata", bus.rsp_rdata, 32'd0);
    check("rsp_rst.req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req("post_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0, 2);

    // Random traffic against the model over the first 256 bytes
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d;
      d = $urandom;
      model_op(1'b1, 2, 1'b0, 32'(4 * w), d, m_rd, m_err, m_lat);
      do_req($sformatf("fill%0d", w), 1'b1, 2'd2, 1'b0, 32'(4 * w), d, m_rd, m_err, m_lat);
    end
    for (int k = 0; k < 250; k++) begin
      logic        wr;
      logic        sg;
      int          sz;
      logic [31:0] addr;
      logic [31:0] wd;
      wr   = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      sz   = int'($urandom_range(0, 3));
      wd   = $urandom;
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << sz) - 1);
      if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h0000_1000;
      model_op(wr, sz, sg, addr, wd, m_rd, m_err, m_lat);
      do_req($sformatf("rnd%0d", k), wr, 2'(sz), sg, addr, wd, m_rd, m_err, m_lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
